ftdi_tx_fifo: RTL and testbench

//  Transmit-side buffer/sequencer feeding the FTDI bus controller's write path.

---
 rtl/ftdi_tx_fifo_if.sv | 31 +++
 rtl/ftdi_tx_fifo.sv | 172 +++++++++++++++++
 tb/tb_ftdi_tx_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ftdi_tx_fifo_if.sv
`default_nettype none
// =============================================================================
// Module   : ftdi_tx_fifo_if
// Brief    : Upstream byte stream, FTDI flow control and write-path signals
//            for ftdi_tx_fifo.
// Revision : 1.0
// =============================================================================
interface ftdi_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  txe;
    logic                  rd_busy;
    logic [7:0]            d;
    logic                  d_asserted;
    logic [DEPTH_LOG2:0]   level;
    logic                  err;

    modport master (
        output in_valid, in_data, txe, rd_busy,
        input  in_ready, d, d_asserted, level, err
    );

    modport slave (
        input  in_valid, in_data, txe, rd_busy,
        output in_ready, d, d_asserted, level, err
    );
endinterface
`default_nettype wire

// File: rtl/ftdi_tx_fifo.sv
`default_nettype none
// =============================================================================
// Module   : ftdi_tx_fifo
// Brief    : FIFO-buffered write sequencer for the FTDI FT245 bus controller.
//            Optional macro FTDI_TX_TIMEOUT_EN adds the txe timeout flush.
// Revision : 1.0
// =============================================================================
module ftdi_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WR_PULSE   = 2,
    parameter int RECOVER    = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              n_rst,
    ftdi_tx_fifo_if.slave     bus
);
    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam int                  CNT_MAX = (WR_PULSE > RECOVER) ? WR_PULSE : RECOVER;
    localparam int                  CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              d_q, d_d;
    logic                    d_asserted_q, d_asserted_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic [7:0]              mem_q [DEPTH];
    logic                    push;
    logic                    pop;
    logic                    flush;

    assign bus.in_ready   = (level_q != FULL);
    assign bus.d          = d_q;
    assign bus.d_asserted = d_asserted_q;
    assign bus.level      = level_q;

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle
    assign push = bus.in_valid & (level_q != FULL) & ~flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((level_q != '0) && !bus.txe && !bus.rd_busy) begin
                    state_d = S_SETUP;
                    d_d     = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                state_d = S_RECOVER;
                cnt_d   = '0;
            end
            S_RECOVER: begin
                if (cnt_q == CNT_W'(RECOVER - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobe is a flop output so the controller's wr never glitches
        d_asserted_d = (state_d == S_STROBE);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            d_q          <= '0;
            d_asserted_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            d_q          <= d_d;
            d_asserted_q <= d_asserted_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef FTDI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    // Counter only runs while data waits in IDLE on a busy device
    always_comb begin
        to_cnt_d = '0;
        err_d    = 1'b0;
        flush    = 1'b0;
        if ((state_q == S_IDLE) && (level_q != '0) && bus.txe) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                flush = 1'b1;
                err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign flush   = (TIMEOUT < 0);
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ftdi_tx_fifo.sv
`default_nettype none
// =============================================================================
// Module   : tb_ftdi_tx_fifo
// Brief    : Directed scoreboard bench for ftdi_tx_fifo (either FTDI_TX_TIMEOUT_EN build).
// Revision : 1.0
// =============================================================================
module tb_ftdi_tx_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int WR_PULSE   = 2;

    logic clk = 1'b0;
    logic n_rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rises = 0;
    int   hi_cnt = 0;
    logic prev_da = 1'b0;
    int   last_push_cyc = 0;
    logic [7:0] sb [$];
    int   rise_cyc [$];

    ftdi_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    ftdi_tx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WR_PULSE  (WR_PULSE),
        .RECOVER   (3),
        .TIMEOUT   (1024)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: scoreboard compare on each rising strobe, width on each fall
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_da = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (bus.d_asserted && !prev_da) begin
                rises++;
                rise_cyc.push_back(cyc);
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("d_byte", bus.d, sb.pop_front());
            end
            if (bus.d_asserted) hi_cnt++;
            if (!bus.d_asserted && prev_da) begin
                check("strobe_width", hi_cnt, WR_PULSE);
                hi_cnt = 0;
            end
            prev_da = bus.d_asserted;
        end
    end

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        sb.push_back(b);
        @(posedge clk); #1;
        last_push_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 10 && n < 3000) begin
            @(negedge clk);
            n++;
            if (sb.size() == 0 && bus.level == 0 && !bus.d_asserted) quiet++;
            else quiet = 0;
        end
        check(tag, 32'(quiet >= 10), 1);
    endtask

    initial begin
        int r0;
        int t0;
        int n;
        logic seen;

        n_rst        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.txe      = 1'b1;
        bus.rd_busy  = 1'b0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_level", bus.level, 0);
        check("rst_d", bus.d, 8'h00);
        check("rst_d_asserted", bus.d_asserted, 0);
        check("rst_err", bus.err, 0);
        @(negedge clk); #2 n_rst = 1'b1;
        @(posedge clk); #1;

        // 2: two bytes, strobes 8 cycles apart
        bus.txe = 1'b0;
        rise_cyc.delete();
        push(8'hA5);
        push(8'h3C);
        wait_drain("t2_drain");
        check("t2_rises", rise_cyc.size(), 2);
        if (rise_cyc.size() == 2) check("t2_spacing", rise_cyc[1] - rise_cyc[0], 8);
        check("t2_level", bus.level, 0);

        // 3: fill to full with txe high, then drain through pointer wrap
        bus.txe = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i * 11));
        check("t3_level_full", bus.level, 16);
        check("t3_in_ready_full", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("t3_level_after_drop", bus.level, 16);
        bus.txe = 1'b0;
        wait_drain("t3_drain");
        check("t3_in_ready_empty", bus.in_ready, 1);

        // 4: rd_busy blocks start but not an in-flight strobe
        bus.rd_busy = 1'b1;
        r0 = rises;
        push(8'h5A);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_strobe", rises, r0);
        check("t4_level_held", bus.level, 1);
        bus.rd_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_setup_d", bus.d, 8'h5A);
        check("t4_setup_da", bus.d_asserted, 0);
        check("t4_setup_level", bus.level, 0);
        @(posedge clk); #1;
        bus.rd_busy = 1'b1;
        wait_drain("t4_drain");
        bus.rd_busy = 1'b0;
        check("t4_rises", rises, r0 + 1);

        // 5: asynchronous reset during strobe
        push(8'hC3);
        push(8'h99);
        n = 0;
        while (!bus.d_asserted && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_strobe_seen", bus.d_asserted, 1);
        #2 n_rst = 1'b0;
        #1;
        check("t5_da_async", bus.d_asserted, 0);
        check("t5_level_async", bus.level, 0);
        check("t5_d_async", bus.d, 8'h00);
        @(negedge clk); #2 n_rst = 1'b1;
        sb.delete();
        r0 = rises;
        repeat (12) @(posedge clk);
        #1;
        check("t5_idle_no_strobe", rises, r0);
        check("t5_idle_level", bus.level, 0);

        // 6: txe held high with data pending
        bus.txe = 1'b1;
        @(posedge clk); #1;
        push(8'h01);
        t0 = last_push_cyc;
        for (int i = 2; i <= 5; i++) push(8'(i));
        check("t6_level5", bus.level, 5);
        seen = 1'b0;
        n = 0;
`ifdef FTDI_TX_TIMEOUT_EN
        while (!seen && n < 1200) begin
            @(negedge clk);
            n++;
            if (bus.err) seen = 1'b1;
        end
        check("t6_err_seen", seen, 1);
        check("t6_err_cycles", cyc - t0, 1024);
        check("t6_flush_level", bus.level, 0);
        @(negedge clk);
        check("t6_err_one_cycle", bus.err, 0);
        sb.delete();
        bus.txe = 1'b0;
        r0 = rises;
        repeat (12) @(posedge clk);
        #1;
        check("t6_no_strobe_after_flush", rises, r0);
`else
        while (n < 1100) begin
            @(negedge clk);
            n++;
            if (bus.err) seen = 1'b1;
        end
        check("t6_err_never", seen, 0);
        check("t6_level_kept", bus.level, 5);
        check("t6_elapsed", 32'(cyc - t0 > 1024), 1);
        bus.txe = 1'b0;
        wait_drain("t6_drain");
`endif
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
